// File: rtl/imem_responder_pkg.sv
// Shared types for the instruction-memory responder: FSM states, width constants
// and the fetch-address check that splits a byte address into word index and error.
package imem_responder_pkg;

  localparam int XLEN       = 32;
  localparam int INSN_BYTES = 4;
  localparam int OFS_BITS   = $clog2(INSN_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [XLEN-OFS_BITS-1:0] word;
    logic                     err;
  } addr_chk_t;

  // Any bit above the RAM index (or inside the byte offset) flags the fetch as bad.
  function automatic addr_chk_t addr_check(input logic [XLEN-1:0] addr, input int idx_bits);
    addr_chk_t r;
    r.word = addr[XLEN-1:OFS_BITS];
    r.err  = (addr[OFS_BITS-1:0] != '0) || ((addr >> (idx_bits + OFS_BITS)) != '0);
    return r;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response bundle between the IF stage (master) and the responder (slave).
interface imem_responder_if #(
  parameter int XLEN = imem_responder_pkg::XLEN
);
  logic            io_req_valid;
  logic            io_req_ready;
  logic [XLEN-1:0] io_req_addr;
  logic            io_resp_valid;
  logic            io_resp_ready;
  logic [XLEN-1:0] io_resp_data;
  logic            io_resp_err;
  logic            io_flush;

  modport master (
    output io_req_valid, io_req_addr, io_resp_ready, io_flush,
    input  io_req_ready, io_resp_valid, io_resp_data, io_resp_err
  );

  modport slave (
    input  io_req_valid, io_req_addr, io_resp_ready, io_flush,
    output io_req_ready, io_resp_valid, io_resp_data, io_resp_err
  );
endinterface

// File: rtl/imem_responder_ram.sv
// Word-addressed instruction store: synchronous write, registered read that holds
// its value until the next read enable. Reads see pre-write contents on a collision.
module imem_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [XLEN-1:0]          i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [XLEN-1:0]          o_rd_data
);
  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/imem_responder.sv
// Fetch responder: one outstanding request, response valid LATENCY cycles after accept,
// held until consumed; flush drops anything in flight. Side port preloads the RAM.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int XLEN    = imem_responder_pkg::XLEN,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  imem_responder_if.slave          bus,
  input  logic                     io_load_en,
  input  logic [$clog2(DEPTH)-1:0] io_load_addr,
  input  logic [XLEN-1:0]          io_load_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_addr;
  logic            r_resp_valid;
  logic            r_err;

  logic            w_req_ready;
  logic            w_accept;
  logic            w_enter;
  logic [XLEN-1:0] w_rd_addr;
  addr_chk_t       w_chk;
  logic [XLEN-1:0] w_rd_data;
  logic            w_unused_hi;

  assign w_req_ready = !bus.io_flush &&
                       (r_state == IDLE || (r_state == RESP && bus.io_resp_ready));
  assign w_accept    = bus.io_req_valid && w_req_ready;

  // With single-cycle latency the RAM read happens on the accept edge itself.
  assign w_rd_addr   = (LATENCY == 1) ? bus.io_req_addr : r_addr;
  assign w_chk       = addr_check(w_rd_addr, AW);
  assign w_unused_hi = ^w_chk.word[XLEN-OFS_BITS-1:AW];
  assign w_enter     = !bus.io_flush &&
                       ((LATENCY == 1) ? w_accept : (r_state == WAIT && r_cnt == CW'(1)));

  imem_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk     (clock),
    .i_rst_n   (reset),
    .i_wr_en   (io_load_en),
    .i_wr_addr (io_load_addr),
    .i_wr_data (io_load_data),
    .i_rd_en   (w_enter),
    .i_rd_addr (w_chk.word[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
    end else if (bus.io_flush) begin
      r_state      <= IDLE;
      r_resp_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= bus.io_req_addr;
        r_cnt  <= CW'(LATENCY - 1);
      end
      if (w_enter) begin
        r_state      <= RESP;
        r_resp_valid <= 1'b1;
        r_err        <= w_chk.err;
      end else if (w_accept) begin
        r_state      <= WAIT;
        r_resp_valid <= 1'b0;
      end else begin
        case (r_state)
          WAIT: r_cnt <= r_cnt - CW'(1);
          RESP: begin
            if (bus.io_resp_ready) begin
              r_state      <= IDLE;
              r_resp_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.io_req_ready  = w_req_ready;
  assign bus.io_resp_valid = r_resp_valid;
  assign bus.io_resp_err   = r_err;
  assign bus.io_resp_data  = r_err ? '0 : w_rd_data;
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the far end of the fetch interface driven by the IF stage.
- Accepts one fetch request (byte address) via valid/ready and returns the 32-bit instruction word after a fixed, parameterised latency; the response is held until the consumer accepts it.
- Backing store is a word-addressed RAM, preloaded through a side load port by the test harness or boot logic.
- Sits between the IF stage and the instruction store; it is the first sequential memory model in the pipeline.

Parameters:
- XLEN, 32, data and address width.
- DEPTH, 256, number of 32-bit words; must be a power of two.
- LATENCY, 2, cycles from request accept to io_resp_valid; must be ≥1.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- io_req_valid  input  1  fetch request present.
- io_req_ready  output  1  responder can accept a request this cycle.
- io_req_addr  input  XLEN  byte address of the instruction.
- io_resp_valid  output  1  response word valid.
- io_resp_ready  input  1  consumer accepts the response.
- io_resp_data  output  XLEN  instruction word; 0 when io_resp_err=1.
- io_resp_err  output  1  request was misaligned or out of range.
- io_flush  input  1  discard any in-flight request or held response.
- io_load_en  input  1  write io_load_data into RAM this cycle.
- io_load_addr  input  log2(DEPTH)  word index for the load.
- io_load_data  input  XLEN  load write data.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, io_resp_valid=0, io_resp_data=0, io_resp_err=0, wait counter=0. RAM contents are not reset.
- FSM states:
  - IDLE: waiting for a request.
  - WAIT: counting down the latency.
  - RESP: holding the response.
- io_req_ready = !io_flush && (state==IDLE || (state==RESP && io_resp_ready)). This allows back-to-back requests without a bubble on the response side.
- Accept when io_req_valid && io_req_ready:
  - Capture the address and set cnt=LATENCY-1.
  - If LATENCY==1, go to RESP next cycle; otherwise go to WAIT.
- WAIT: decrement cnt each cycle. When cnt==1 at a clock edge, move to RESP on that edge. io_resp_valid therefore rises exactly LATENCY cycles after the accept edge.
- Entering RESP:
  - Register io_resp_data from RAM[addr[log2(DEPTH)+1:2]].
  - Register io_resp_err = (addr[1:0]!=0) || (addr[XLEN-1:log2(DEPTH)+2]!=0).
  - On error, io_resp_data=0.
- RESP: io_resp_valid=1. Data and err are held stable while io_resp_ready=0.
  - On handshake without a new accept: go to IDLE, io_resp_valid=0.
  - On handshake with a same-cycle accept: start the new request per the accept rule.
- io_flush (any state):
  - Next state is IDLE and io_resp_valid=0.
  - The held response is dropped, even if io_resp_ready=1 in the same cycle; the consumer must ignore it.
  - No request is accepted that cycle.
- Load port:
  - The write occurs every cycle io_load_en=1, independent of FSM state.
  - A load to the word being read on the RESP-entry edge returns the old data (read-before-write).
  - Loads never disturb a held response.
- Address width: the index uses the low log2(DEPTH) bits above the byte offset; no wrap-around is permitted. Upper bits set means err.
- Only one request is outstanding at a time. There is no internal queue.

Decomposition:
- Shared package:
  - FSM state enum {IDLE, WAIT, RESP}.
  - Constants XLEN=32 and INSN_BYTES=4.
  - An address-check function returning {index, err} from a byte address.
- One natural sub-module: imem_ram, a DEPTH×XLEN array with a synchronous write port and a registered read port.
- The FSM and latency counter stay in imem_responder.

Test Plan:
- Load RAM[0]=0x00000013, RAM[1]=0x00a00093; request 0x0 (LATENCY=2) with io_resp_ready=1 -> io_resp_valid high 2 cycles after accept, data 0x00000013, err=0. Then request 0x4 -> data 0x00a00093.
- Back-pressure: request 0x4 with io_resp_ready=0 for 5 cycles -> valid and data 0x00a00093 held stable, io_req_ready=0. Raise ready with a new request 0x0 valid -> same-cycle handoff, next response 0x00000013 2 cycles later.
- Misaligned 0x2 -> err=1, data=0. Out of range 0x400 (DEPTH=256) -> err=1, data=0.
- Flush in WAIT one cycle after accept -> no io_resp_valid at all; io_req_ready returns to 1 the cycle after flush.
- Flush in RESP with io_resp_ready=1 -> next cycle valid=0, state IDLE.
- Assert reset=0 asynchronously mid-WAIT (no clock edge) -> io_resp_valid=0 immediately. After release, a request for 0x0 returns the RAM value loaded before reset.
- LATENCY=1 build: request 0x4 -> valid on the very next cycle. Load RAM[1]=0xdeadbeef on the same edge as the read -> old value 0x00a00093 returned; a re-request returns 0xdeadbeef.
